// File: rtl/hexdisp_pkg.sv
// Shared types and constants for the hex seven-segment display controller.
package hexdisp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } hexdisp_state_t;

endpackage

// File: rtl/hex_display_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (bit order gfedcba).
module hex7seg
  import hexdisp_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg7_t      o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b0100111;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: latches a hex word, then sweeps digits MSB-first
// through one shared decoder. Optional display flashing under HEXDISP_BLINK_EN.
module hex_display_ctrl
  import hexdisp_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_blank,
  input  logic                  blink,
  output logic                  ready,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

  hexdisp_state_t            r_state, w_state_nx;
  logic [DIGITS-1:0][3:0]    r_val;
  seg7_t [DIGITS-1:0]        r_seg;
  logic [IW-1:0]             r_idx;
  logic                      r_lz;
  logic                      r_seen_nz;
  logic                      r_done;

  logic                      w_accept;
  logic                      w_last;
  logic [3:0]                w_nib;
  seg7_t                     w_dec;
  logic                      w_blank;

  assign w_nib = r_val[r_idx];

  hex7seg u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Leading zeros are blanked until the first nonzero nibble; digit 0 always shows.
  assign w_blank = r_lz && !r_seen_nz && (w_nib == 4'h0) && (r_idx != '0);

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_accept   = 1'b1;
          w_state_nx = SWEEP;
        end
      end
      SWEEP: begin
        if (r_idx == '0) begin
          w_last     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_val     <= '0;
      r_lz      <= 1'b0;
      r_idx     <= IDX_TOP;
      r_seen_nz <= 1'b0;
      r_seg     <= {DIGITS{SEG_BLANK}};
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_last;
      if (w_accept) begin
        r_val     <= value;
        r_lz      <= lz_blank;
        r_idx     <= IDX_TOP;
        r_seen_nz <= 1'b0;
      end
      if (r_state == SWEEP) begin
        r_seg[r_idx] <= w_blank ? SEG_BLANK : w_dec;
        if (w_nib != 4'h0) r_seen_nz <= 1'b1;
        if (!w_last) r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = r_done;

`ifdef HEXDISP_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] r_blk_cnt;
  logic          r_blk_on;

  // Free-running half-period counter; phase only gates the output, never r_seg.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_blk_cnt <= '0;
      r_blk_on  <= 1'b1;
    end else if (r_blk_cnt == CW'(BLINK_DIV - 1)) begin
      r_blk_cnt <= '0;
      r_blk_on  <= ~r_blk_on;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign seg = (blink && !r_blk_on) ? {DIGITS{SEG_BLANK}} : r_seg;
`else
  logic w_unused_blink;
  assign w_unused_blink = blink & (BLINK_DIV > 1);
  assign seg = r_seg;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: expected final displays are queued at load time
// and compared by a monitor whenever the DUT pulses done.
module tb_hex_display_ctrl;

  localparam int D  = 8;
  localparam int SW = 7 * D;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b0100111, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          load = 1'b0;
  logic [4*D-1:0] value = '0;
  logic          lz_blank = 1'b0;
  logic          blink = 1'b0;
  logic          ready, done;
  logic [SW-1:0] seg;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];

  hex_display_ctrl #(.DIGITS(D), .BLINK_DIV(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (load),
    .value    (value),
    .lz_blank (lz_blank),
    .blink    (blink),
    .ready    (ready),
    .done     (done),
    .seg      (seg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending sweep");
      end else begin
        chk("sweep_result", seg, exp_q.pop_front());
      end
    end
  end

  // Drive load for one cycle from a negedge; returns at the next negedge.
  task automatic issue(input logic [31:0] v, input logic lz, input bit push, input logic [SW-1:0] e);
    load = 1'b1; value = v; lz_blank = lz;
    if (push) exp_q.push_back(e);
    @(negedge CLK);
    load = 1'b0; value = '0; lz_blank = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nblank;
    repeat (2) @(negedge CLK);
    chk("reset_seg",   seg, {D{BL}});
    chk("reset_ready", SW'(ready), SW'(1));
    chk("reset_done",  SW'(done), SW'(0));
    nRST = 1'b1;
    @(negedge CLK);

    // Plain load; check first-digit latency and ready drop
    issue(32'h1234ABCD, 1'b0, 1'b1, {S1, S2, S3, S4, SA, SB, SC, SD});
    chk("ready_low_in_sweep", SW'(ready), SW'(0));
    @(negedge CLK);
    chk("digit7_edge1", SW'(seg[SW-1 -: 7]), SW'(S1));
    wait_done();
    chk("ready_at_done", SW'(ready), SW'(1));
    @(negedge CLK);

    // Leading-zero blanking
    issue(32'h000000F0, 1'b1, 1'b1, {{6{BL}}, SF, S0});
    wait_done();
    @(negedge CLK);
    issue(32'h00000000, 1'b1, 1'b1, {{7{BL}}, S0});
    wait_done();
    @(negedge CLK);
    issue(32'h00A00B00, 1'b1, 1'b1, {BL, BL, SA, S0, S0, SB, S0, S0});
    wait_done();
    @(negedge CLK);

    // Load during sweep is ignored
    issue(32'h11111111, 1'b0, 1'b1, {D{S1}});
    @(negedge CLK);
    load = 1'b1; value = 32'h22222222;
    @(negedge CLK);
    load = 1'b0; value = '0;
    wait_done();
    chk("ready_after_ignored", SW'(ready), SW'(1));
    @(negedge CLK);

    // Back-to-back: load in the done cycle
    issue(32'h76543210, 1'b0, 1'b1, {S7, S6, S5, S4, S3, S2, S1, S0});
    wait_done();
    issue(32'h89ABCDEF, 1'b1, 1'b1, {S8, S9, SA, SB, SC, SD, SE, SF});
    chk("b2b_accepted", SW'(ready), SW'(0));
    @(negedge CLK);
    chk("b2b_digit7", SW'(seg[SW-1 -: 7]), SW'(S8));
    wait_done();
    @(negedge CLK);

    // Reset mid-sweep: no done, everything blank
    issue(32'hFFFFFFFF, 1'b0, 1'b0, '0);
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    chk("midreset_seg",   seg, {D{BL}});
    chk("midreset_ready", SW'(ready), SW'(1));
    chk("midreset_done",  SW'(done), SW'(0));
    nRST = 1'b1;
    repeat (12) @(negedge CLK);

    // Blink
    issue(32'h00000008, 1'b0, 1'b1, {{7{S0}}, S8});
    wait_done();
    @(negedge CLK);
    blink = 1'b1;
    nblank = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (seg === {D{BL}}) nblank++;
      else chk("blink_pattern", seg, {{7{S0}}, S8});
    end
`ifdef HEXDISP_BLINK_EN
    chk("blink_blank_cycles", SW'(nblank), SW'(8));
`else
    chk("blink_blank_cycles", SW'(nblank), SW'(0));
`endif
    blink = 1'b0;
    #1;
    chk("blink_release", seg, {{7{S0}}, S8});

    repeat (2) @(negedge CLK);
    chk("queue_drained", SW'(exp_q.size()), SW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
